// File: rtl/host_output_queue.sv
// rtl/host_output_queue.sv - frame queue presenting emulator output to host wire-outs with toggle acknowledge
// Head frame is held stable until the host flips host_pop_tog; each flip retires exactly one frame.
module host_output_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_o_valid,
    output logic              io_o_ready,
    input  logic [DATA_W-1:0] io_o_bits,
    input  logic              host_pop_tog,
    output logic              host_valid,
    output logic [DATA_W-1:0] host_data,
    output logic [CNT_W-1:0]  host_occupancy,
    output logic [CNT_W-1:0]  host_pop_count,
    output logic              host_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] POP_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              tog_q, tog_d;
    logic [CNT_W-1:0]  pop_count_q, pop_count_d;
    logic              underflow_q, underflow_d;
    logic              enq;
    logic              host_evt;
    logic              pop;

    // Ready comes from registers only, so there is no path from io_o_valid.
    assign io_o_ready = !reset && (count_q != FULL_CNT);

    always_comb begin
        enq         = io_o_valid && io_o_ready;
        host_evt    = (host_pop_tog != tog_q);
        pop         = host_evt && (count_q != '0);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        tog_d       = host_pop_tog;
        pop_count_d = pop_count_q;
        underflow_d = underflow_q;

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            pop_count_d = pop_count_q + POP_ONE;
        end
        // An ack against an empty queue is consumed, never deferred to a later frame.
        if (host_evt && (count_q == '0)) begin
            underflow_d = 1'b1;
        end

        case ({enq, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tog_q       <= host_pop_tog;
            pop_count_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tog_q       <= tog_d;
            pop_count_q <= pop_count_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= io_o_bits;
        end
    end

    assign host_valid     = (count_q != '0);
    assign host_data      = mem_q[rd_ptr_q];
    assign host_occupancy = CNT_W'(count_q);
    assign host_pop_count = pop_count_q;
    assign host_underflow = underflow_q;

endmodule

// File: tb/tb_host_output_queue.sv
// tb/tb_host_output_queue.sv - self-checking bench for host_output_queue
module tb_host_output_queue;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              io_o_valid = 1'b0;
    logic              io_o_ready;
    logic [DATA_W-1:0] io_o_bits = '0;
    logic              host_pop_tog = 1'b0;
    logic              host_valid;
    logic [DATA_W-1:0] host_data;
    logic [CNT_W-1:0]  host_occupancy;
    logic [CNT_W-1:0]  host_pop_count;
    logic              host_underflow;

    host_output_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_o_valid     (io_o_valid),
        .io_o_ready     (io_o_ready),
        .io_o_bits      (io_o_bits),
        .host_pop_tog   (host_pop_tog),
        .host_valid     (host_valid),
        .host_data      (host_data),
        .host_occupancy (host_occupancy),
        .host_pop_count (host_pop_count),
        .host_underflow (host_underflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] popped[$];
    logic [DATA_W-1:0] sent[$];
    int                m_pc = 0;
    bit                m_uf = 1'b0;

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              flip;
        logic              exp_valid;
        int                exp_occ;
        int                exp_pc;
        logic              exp_uf;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("host_valid", 64'(host_valid), 64'(mq.size() != 0));
        chk("occupancy", 64'(host_occupancy), 64'(mq.size()));
        chk("pop_count", 64'(host_pop_count), 64'(m_pc));
        chk("underflow", 64'(host_underflow), 64'(m_uf));
        chk("io_o_ready", 64'(io_o_ready), 64'(mq.size() != DEPTH));
        if (mq.size() != 0) chk("head_data", host_data, mq[0]);
    endtask

    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic flip, output bit accepted);
        int sz;
        bit pop_e;
        bit uf_e;
        sz = mq.size();
        accepted = v && (sz != DEPTH);
        pop_e = flip && (sz != 0);
        uf_e = flip && (sz == 0);
        io_o_valid = v;
        io_o_bits = d;
        if (flip) host_pop_tog = ~host_pop_tog;
        @(posedge clock);
        #1;
        if (pop_e) begin
            popped.push_back(mq.pop_front());
            m_pc = (m_pc + 1) % (1 << CNT_W);
        end
        if (uf_e) m_uf = 1'b1;
        if (accepted) mq.push_back(d);
        io_o_valid = 1'b0;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io_o_valid = 1'b0;
        @(posedge clock);
        #1;
        mq.delete();
        popped.delete();
        sent.delete();
        m_pc = 0;
        m_uf = 1'b0;
        chk("ready_in_reset", 64'(io_o_ready), 64'd0);
        chk("valid_in_reset", 64'(host_valid), 64'd0);
        chk("occ_in_reset", 64'(host_occupancy), 64'd0);
        chk("pc_in_reset", 64'(host_pop_count), 64'd0);
        chk("uf_in_reset", 64'(host_underflow), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'(io_o_ready), 64'd1);
    endtask

    initial begin
        bit acc;
        logic [DATA_W-1:0] r;
        int idx;
        int n_acc;

        vecs[0] = '{1'b1, 64'h0004_0003_0002_0001, 1'b0, 1'b1, 1, 0, 1'b0, 64'h0004_0003_0002_0001};
        vecs[1] = '{1'b0, 64'h0, 1'b0, 1'b1, 1, 0, 1'b0, 64'h0004_0003_0002_0001};
        vecs[2] = '{1'b0, 64'h0, 1'b1, 1'b0, 0, 1, 1'b0, 64'h0};
        vecs[3] = '{1'b0, 64'h0, 1'b0, 1'b0, 0, 1, 1'b0, 64'h0};
        vecs[4] = '{1'b1, 64'hAAAA_5555_AAAA_5555, 1'b1, 1'b1, 1, 1, 1'b1, 64'hAAAA_5555_AAAA_5555};
        vecs[5] = '{1'b0, 64'h0, 1'b1, 1'b0, 0, 2, 1'b1, 64'h0};
        vecs[6] = '{1'b1, 64'h0000_0000_0000_BBBB, 1'b0, 1'b1, 1, 2, 1'b1, 64'h0000_0000_0000_BBBB};
        vecs[7] = '{1'b1, 64'h0000_0000_0000_CCCC, 1'b1, 1'b1, 1, 3, 1'b1, 64'h0000_0000_0000_CCCC};
        vecs[8] = '{1'b0, 64'h0, 1'b1, 1'b0, 0, 4, 1'b1, 64'h0};

        // Single frame, then empty-queue ack colliding with an enqueue.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].flip, acc);
            chk($sformatf("vec%0d_valid", i), 64'(host_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_occ", i), 64'(host_occupancy), 64'(vecs[i].exp_occ));
            chk($sformatf("vec%0d_pc", i), 64'(host_pop_count), 64'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_uf", i), 64'(host_underflow), 64'(vecs[i].exp_uf));
            if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), host_data, vecs[i].exp_data);
        end

        // Fill and backpressure, then paced toggles draining 1..10.
        do_reset();
        idx = 1;
        n_acc = 0;
        for (int t = 0; t < 12; t++) begin
            step(idx <= 10, 64'(idx), 1'b0, acc);
            if (acc) begin idx++; n_acc++; end
        end
        chk("fill_accepted", 64'(n_acc), 64'd8);
        chk("fill_ready", 64'(io_o_ready), 64'd0);
        chk("fill_occ", 64'(host_occupancy), 64'd8);
        for (int t = 0; t < 50; t++) begin
            step(idx <= 10, 64'(idx), (t % 5) == 0, acc);
            if (acc) idx++;
        end
        chk("drain_count", 64'(popped.size()), 64'd10);
        for (int i = 0; i < popped.size(); i++) chk($sformatf("drain_order%0d", i), popped[i], 64'(i + 1));
        chk("drain_pc", 64'(host_pop_count), 64'd10);

        // Wrap-around with occupancy between 1 and 3.
        do_reset();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            r = {$urandom, $urandom};
            step(1'b1, r, 1'b0, acc);
            if (acc) sent.push_back(r);
            if (i >= 1) step(1'b0, 64'h0, 1'b1, acc);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 64'h0, mq.size() != 0, acc);
        chk("wrap_count", 64'(popped.size()), 64'(3 * DEPTH));
        for (int i = 0; i < popped.size() && i < sent.size(); i++)
            chk($sformatf("wrap_data%0d", i), popped[i], sent[i]);

        // Simultaneous enqueue and pop at occupancy 4.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 64'(100 + i), 1'b0, acc);
        step(1'b1, 64'd104, 1'b1, acc);
        chk("sim_occ", 64'(host_occupancy), 64'd4);
        chk("sim_head", host_data, 64'd101);

        // Underflow is sticky and the next frame still arrives intact.
        do_reset();
        step(1'b0, 64'h0, 1'b1, acc);
        chk("uf_set", 64'(host_underflow), 64'd1);
        chk("uf_pc", 64'(host_pop_count), 64'd0);
        step(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, acc);
        step(1'b0, 64'h0, 1'b0, acc);
        chk("uf_frame", host_data, 64'hDEAD_BEEF_0123_4567);
        chk("uf_sticky", 64'(host_underflow), 64'd1);

        // Reset mid-stream with the toggle level changing under reset.
        for (int i = 0; i < 4; i++) step(1'b1, 64'(200 + i), 1'b0, acc);
        chk("pre_reset_occ", 64'(host_occupancy), 64'd5);
        host_pop_tog = ~host_pop_tog;
        do_reset();
        step(1'b0, 64'h0, 1'b0, acc);
        chk("rst_valid", 64'(host_valid), 64'd0);
        chk("rst_pc", 64'(host_pop_count), 64'd0);
        step(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, acc);
        chk("rst_next_frame", host_data, 64'h1234_5678_9ABC_DEF0);
        step(1'b0, 64'h0, 1'b1, acc);
        chk("rst_next_pc", 64'(host_pop_count), 64'd1);
        chk("rst_next_empty", 64'(host_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/host_output_queue.md
# host_output_queue

Buffers the emulator's decoupled output stream (`io_o`, four 16-bit words per frame) and presents it to the Opal Kelly host through level-only wire endpoints. Wire-outs cannot express a handshake, so each frame is held stable until the host acknowledges it with a toggle bit. This gives exactly-once delivery regardless of host polling rate. The block sits between `OpalKellyEmulatorModuleTop`'s `io_o` port and the `okWireIn`/`okWireOut` endpoints, replacing the raw `io_o_ready`/`io_o_valid` wires.

## Interface
- `DATA_W`, 64: frame width; must be a multiple of 16.
- `DEPTH`, 8: queue entries; power of two, at least 2.
- `CNT_W`, 16: width of the host-visible counters.

Ports:
- `clock`  in  1  system clock (`sys_clk`); every signal is in this domain, and wire-in values arrive already synchronized.
- `reset`  in  1  synchronous, active-high.
- `io_o_valid`  in  1  emulator frame valid.
- `io_o_ready`  out  1  queue can accept a frame.
- `io_o_bits`  in  DATA_W  emulator frame; word 0 is `[15:0]`.
- `host_pop_tog`  in  1  wire-in bit; each level change acknowledges the current head frame.
- `host_valid`  out  1  wire-out; a head frame is present.
- `host_data`  out  DATA_W  wire-out; the head frame.
- `host_occupancy`  out  CNT_W  number of entries held, zero-extended.
- `host_pop_count`  out  CNT_W  frames delivered to the host; wraps modulo 2^CNT_W.
- `host_underflow`  out  1  sticky; set when the host acknowledges while the queue is empty.

## Operation
- Storage is a circular buffer: `DEPTH` entries, read and write pointers of log2(`DEPTH`) bits, and a count register of log2(`DEPTH`)+1 bits.
- Enqueue happens on any edge where `io_o_valid && io_o_ready`. `io_o_bits` is written at the write pointer, and the write pointer increments and wraps.
- `io_o_ready = !reset && (count != DEPTH)`. It is decoded from registers only, so there is no combinational path from `io_o_valid`.
- The block registers the previous value of `host_pop_tog` in `tog_q`. A host event is `host_pop_tog != tog_q`. `tog_q` loads `host_pop_tog` every cycle.
- Host event with count ≠ 0 (a pop):
  - the read pointer increments and wraps;
  - `host_pop_count` increments.
- Host event with count = 0:
  - no pop;
  - `host_underflow` is set;
  - `tog_q` still tracks the input, so the event is consumed and not deferred.
- The count register holds the queue occupancy. On each clock edge:
  - it increments on enqueue only;
  - it decrements on pop only;
  - it is unchanged when enqueue and pop occur on the same edge.
- Output decode:
  - `host_valid = (count != 0)`;
  - `host_data = mem[rd_ptr]`;
  - `host_occupancy = count`.
- All three outputs depend only on registers, so they are stable between host events.
- Host software protocol:
  1. poll until `host_valid = 1`;
  2. read the `host_data` words;
  3. flip `host_pop_tog`;
  4. re-poll.
- The block guarantees the head frame does not change until step 3.

## Timing
- Reset:
  - pointers and count are 0;
  - `tog_q` is loaded from `host_pop_tog` at reset, so a stale level is not treated as an event;
  - `io_o_ready` = 0 during reset and 1 on the first cycle after reset;
  - `host_valid` = 0;
  - `host_occupancy` = 0;
  - `host_pop_count` = 0;
  - `host_underflow` = 0;
  - `host_data` is don't-care.
- Enqueue-to-visible latency is 1 cycle. If the queue is empty and a frame is accepted at edge N, `host_valid` = 1 with that frame on `host_data` after edge N.
- Ack-to-advance latency is 1 cycle. If `host_pop_tog` flips before edge N, the next frame (or `host_valid` = 0) appears after edge N.
- Full queue: `io_o_ready` is 0. A pop at edge N raises `io_o_ready` after edge N; the earliest enqueue is at edge N+1.
- Empty queue with a simultaneous enqueue and host event: the event counts as an underflow. The enqueued frame remains queued.
- A pop while the queue is not full may coincide with an enqueue.
- Reset mid-operation: all queued frames are discarded, with no partial-state carryover, and the counters clear.
- Pointers wrap from `DEPTH-1` to 0 with no gap.

## Test plan
- **Single frame:** after reset, drive `io_o_bits` = 0x0004_0003_0002_0001 with valid for 1 cycle. Expect `host_valid` = 1 and that `host_data` on the next cycle. Flip `host_pop_tog`. Expect `host_valid` = 0 one cycle later and `host_pop_count` = 1.
- **Fill and backpressure:** hold `io_o_valid` with data 1..10. Expect exactly 8 frames accepted, `io_o_ready` = 0, and `host_occupancy` = 8. Issue 10 toggles, each 5 cycles apart. Expect data to pop in the order 1..10 and `host_pop_count` = 10.
- **Wrap-around:** run 3×`DEPTH` frames with interleaved enqueue and pop, occupancy held between 1 and 3. Expect the output to match a FIFO model exactly, with no loss and no duplication.
- **Simultaneous enqueue and pop at occupancy 4:** expect occupancy to stay at 4 and the head to advance by exactly one.
- **Underflow:** flip `host_pop_tog` while the queue is empty. Expect `host_underflow` = 1 (sticky), `host_pop_count` unchanged, and the next enqueued frame still delivered intact.
- **Reset mid-stream:** with 5 frames queued, assert `reset` for 1 cycle. Expect:
  - occupancy = 0;
  - `host_valid` = 0;
  - counters = 0;
  - no spurious pop from the `host_pop_tog` level;
  - the next frame is delivered normally.
